// File: rtl/ej32_pkg.sv
// ej32_pkg: shared width typedefs and divider sequencer types.
package ej32_pkg;
    typedef logic U1;
    typedef logic [31:0] DU;
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} div_st_t;
    typedef enum logic {DIV_Q = 1'b0, DIV_R = 1'b1} div_op_t;
endpackage

// File: rtl/div_int.sv
// div_int: unsigned restoring divider, one quotient bit per cycle.
// rst loads x/y and launches DSZ iterations; busy stays high until they finish.
module div_int #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic [DSZ-1:0] q,
    output logic [DSZ-1:0] r
);
    localparam int NW = $clog2(DSZ + 1);
    logic [DSZ-1:0] d;
    logic [NW-1:0] n;
    logic [DSZ:0] t, s;
    assign t = {r, q[DSZ-1]};
    assign s = t - {1'b0, d};
    assign busy = n != '0;
    always_ff @(posedge clk)
        if (rst) begin
            q <= x;
            r <= '0;
            d <= y;
            n <= NW'(DSZ);
        end else if (busy) begin
            r <= s[DSZ] ? t[DSZ-1:0] : s[DSZ-1:0];
            q <= {q[DSZ-2:0], ~s[DSZ]};
            n <= n - 1'b1;
        end
endmodule

// File: rtl/div_seq.sv
// div_seq: signed JVM idiv/irem sequencer around the unsigned div_int core.
// Define DIV_FASTPATH_EN to bypass the core for divisors 0, 1 and -1.
module div_seq
    import ej32_pkg::*;
#(
    parameter int DSZ = $bits(DU)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           op,
    input  logic [DSZ-1:0] a,
    input  logic [DSZ-1:0] b,
    output logic           rdy,
    output logic           done,
    output logic           dz,
    output logic [DSZ-1:0] res
);
    div_st_t st;
    div_op_t opr;
    U1 sa, sb, fp, start, arm, busy, fast_ok;
    logic [DSZ-1:0] ma, mb, cq, cr, qm, rm, qs, rs;
`ifdef DIV_FASTPATH_EN
    assign fast_ok = b == '0 || b == DSZ'(1) || &b;
`else
    assign fast_ok = 1'b0;
`endif
    assign rdy = st == IDLE && !done;
    // fast path: |b| is 0 or 1, so the quotient magnitude is |a| and remainder is 0
    assign qm = fp ? ma : cq;
    assign rm = fp ? '0 : cr;
    assign qs = (sa ^ sb) ? -qm : qm;
    assign rs = sa ? -rm : rm;
    div_int #(.DSZ(DSZ)) u_core (
        .clk (clk),
        .rst (start),
        .x   (ma),
        .y   (mb),
        .busy(busy),
        .q   (cq),
        .r   (cr)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st    <= IDLE;
            opr   <= DIV_Q;
            sa    <= 1'b0;
            sb    <= 1'b0;
            fp    <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            start <= 1'b0;
            arm   <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            res   <= '0;
        end else begin
            start <= 1'b0;
            arm   <= start;
            done  <= 1'b0;
            case (st)
                IDLE: if (req && rdy) begin
                    opr   <= div_op_t'(op);
                    sa    <= a[DSZ-1];
                    sb    <= b[DSZ-1];
                    ma    <= a[DSZ-1] ? -a : a;
                    mb    <= b[DSZ-1] ? -b : b;
                    fp    <= fast_ok;
                    start <= !fast_ok;
                    st    <= fast_ok ? FIX : PREP;
                end
                PREP: st <= RUN;
                // the core's busy is stale until it has seen start
                RUN: if (!arm && !busy) st <= FIX;
                FIX: begin
                    res  <= mb == '0 ? '0 : (opr == DIV_R ? rs : qs);
                    dz   <= mb == '0;
                    done <= 1'b1;
                    st   <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: random and directed checks of div_seq against a 64-bit arithmetic model.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst, req, op, rdy, done, dz;
    logic [31:0] a, b, res;
    int vectors = 0, miss = 0, cyc = 0, due = 0;
    bit pend = 0;
    logic [31:0] exp_res = '0;
    logic exp_dz = 1'b0;

    always #5 clk = ~clk;

    div_seq #(.DSZ(32)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .op  (op),
        .a   (a),
        .b   (b),
        .rdy (rdy),
        .done(done),
        .dz  (dz),
        .res (res)
    );

    function automatic logic [32:0] ref_div(input logic [31:0] x, y, input logic o);
        longint lx, ly, q, r;
        if (y == '0) return {1'b1, 32'h0};
        lx = $signed(x);
        ly = $signed(y);
        q = lx / ly;
        r = lx % ly;
        return {1'b0, o ? r[31:0] : q[31:0]};
    endfunction

    function automatic int lat_of(input logic [31:0] y);
`ifdef DIV_FASTPATH_EN
        return (y == 32'd0 || y == 32'd1 || y == 32'hFFFF_FFFF) ? 1 : 35;
`else
        return 35;
`endif
    endfunction

    function automatic logic [31:0] rnd_a();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return $urandom_range(0, 300) - 150;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_b();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 40) - 20;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, exp);
        vectors++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    // reference model: accepts whenever idle, result due a fixed number of edges later
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend = 0;
            exp_res = '0;
            exp_dz = 1'b0;
        end else if (!pend) begin
            if (req) begin
                {exp_dz, exp_res} = ref_div(a, b, op);
                pend = 1;
                due = cyc + lat_of(b);
            end
        end else if (cyc == due + 1) pend = 0;
    end

    always @(negedge clk)
        if (!rst) begin
            chk("rdy", {31'd0, rdy}, {31'd0, !pend});
            chk("done", {31'd0, done}, {31'd0, pend && cyc == due});
            if (!pend || cyc == due) begin
                chk("res", res, exp_res);
                chk("dz", {31'd0, dz}, {31'd0, exp_dz});
            end
        end

    task automatic do_op(input logic [31:0] ia, ib, input logic iop, input logic [31:0] xr, input logic xdz);
        int n;
        n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", {31'd0, rdy}, 32'd1);
        a = ia;
        b = ib;
        op = iop;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat_of(ib));
        chk("op_res", res, xr);
        chk("op_dz", {31'd0, dz}, {31'd0, xdz});
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        chk("rst_res", res, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("model_q", ref_div(32'd100, 32'd7, 1'b0), 33'd14);
        chk("model_r", ref_div(-32'd100, 32'd7, 1'b1), {1'b0, 32'hFFFF_FFFE});
        chk("model_min", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0), {1'b0, 32'h8000_0000});
        chk("model_dz", ref_div(32'd5, 32'd0, 1'b0), {1'b1, 32'd0});
        do_op(32'd100, 32'd7, 1'b0, 32'd14, 1'b0);
        do_op(32'd100, 32'd7, 1'b1, 32'd2, 1'b0);
        do_op(-32'd100, 32'd7, 1'b0, -32'd14, 1'b0);
        do_op(-32'd100, 32'd7, 1'b1, -32'd2, 1'b0);
        do_op(32'd100, -32'd7, 1'b0, -32'd14, 1'b0);
        do_op(32'd100, -32'd7, 1'b1, 32'd2, 1'b0);
        do_op(-32'd100, -32'd7, 1'b0, 32'd14, 1'b0);
        do_op(-32'd100, -32'd7, 1'b1, -32'd2, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0);
        do_op(32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 1'b0);
        do_op(32'd5, 32'd0, 1'b0, 32'd0, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFF, 1'b0, -32'd7, 1'b0);
        req = 1'b1;
        repeat (150) begin
            @(negedge clk);
            a = rnd_a();
            b = rnd_b();
            op = 1'($urandom);
        end
        req = 1'b0;
        repeat (40) @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        op = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd9, 32'd3, 1'b0, 32'd3, 1'b0);
        repeat (6000) begin
            @(negedge clk);
            req = $urandom_range(0, 3) != 0;
            a = rnd_a();
            b = rnd_b();
            op = 1'($urandom);
        end
        req = 1'b0;
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
